// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared types and constants for the two-master GPIO bus arbiter.
// Optional feature macro: GPIO_ARB_LOCK_EN (consumed by the arbiter, interface and rr_arb2).
package gpio_arb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 2;

    // GPIO block address map
    localparam logic [1:0] GPI1 = 2'd0;
    localparam logic [1:0] GPI2 = 2'd1;
    localparam logic [1:0] GPO1 = 2'd2;
    localparam logic [1:0] GPO2 = 2'd3;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    // Id of the other master in a two-master system
    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// gpio_bus_arbiter_if: one master's request/response channel into the arbiter.
// With GPIO_ARB_LOCK_EN defined the channel also carries a lock request.
interface gpio_bus_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic              gnt;
    logic              ack;
    logic [DATA_W-1:0] rd;
`ifdef GPIO_ARB_LOCK_EN
    logic              lock;

    modport master (output req, we, a, wd, lock, input gnt, ack, rd);
    modport slave  (input req, we, a, wd, lock, output gnt, ack, rd);
`else
    modport master (output req, we, a, wd, input gnt, ack, rd);
    modport slave  (input req, we, a, wd, output gnt, ack, rd);
`endif
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin winner select with a registered priority pointer.
// The pointer moves to the non-winner on each completed transaction.
// With GPIO_ARB_LOCK_EN defined, a winner holding its lock keeps priority until it
// drops the lock at a completion or while the arbiter is idle.
module rr_arb2
    import gpio_arb_pkg::*;
#(
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,   // a transaction is completing this cycle
    input  logic       winner,   // id of the completing master
`ifdef GPIO_ARB_LOCK_EN
    input  logic       idle,     // sequencer is idle this cycle
    input  logic [1:0] lock,
`endif
    output logic       grant_id,
    output logic       any_req
);

    logic ptr_q;
    logic eff_ptr;

`ifdef GPIO_ARB_LOCK_EN
    logic lock_q;
    logic release_lock;

    // Owner of an active lock is always the pointer holder
    assign release_lock = lock_q && !lock[ptr_q];
    assign eff_ptr      = release_lock ? other_id(ptr_q) : ptr_q;

    // Pointer and lock state: pin on a locked completion, rotate otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= INIT_PRIO;
            lock_q <= 1'b0;
        end else if (update) begin
            if (lock[winner]) begin
                ptr_q  <= winner;
                lock_q <= 1'b1;
            end else begin
                ptr_q  <= other_id(winner);
                lock_q <= 1'b0;
            end
        end else if (idle && release_lock) begin
            ptr_q  <= other_id(ptr_q);
            lock_q <= 1'b0;
        end
    end
`else
    assign eff_ptr = ptr_q;

    // Pointer register: hand priority to the non-winner on each completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= INIT_PRIO;
        end else if (update) begin
            ptr_q <= other_id(winner);
        end
    end
`endif

    // Winner select: a lone requester wins, contention is settled by the pointer
    always_comb begin
        any_req = |req;
        if (&req) begin
            grant_id = eff_ptr;
        end else begin
            grant_id = req[1];
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: shares the GPIO slave port between two masters (M0, M1).
// Each transaction runs IDLE -> ISSUE -> RESP; the GPIO write strobe is high only
// in ISSUE, read data is captured at the end of ISSUE and returned with ACK in RESP.
// Optional feature macro: GPIO_ARB_LOCK_EN (adds per-master lock via the interface).
module gpio_bus_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned INIT_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_bus_arbiter_if.slave    m0,
    gpio_bus_arbiter_if.slave    m1,
    output logic [ADDR_W-1:0]    gpio_a,
    output logic                 gpio_we,
    output logic [DATA_W-1:0]    gpio_wd,
    input  logic [DATA_W-1:0]    gpio_rd
);

    state_t              state_q;
    logic                win_q;
    logic [1:0]          gnt_q;
    logic [1:0]          ack_q;
    logic [DATA_W-1:0]   rd0_q;
    logic [DATA_W-1:0]   rd1_q;

    logic                grant_id;
    logic                any_req;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_wd;

    rr_arb2 #(
        .INIT_PRIO (INIT_PRIO != 0)
    ) u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .req      ({m1.req, m0.req}),
        .update   (state_q == RESP),
        .winner   (win_q),
`ifdef GPIO_ARB_LOCK_EN
        .idle     (state_q == IDLE),
        .lock     ({m1.lock, m0.lock}),
`endif
        .grant_id (grant_id),
        .any_req  (any_req)
    );

    // Request fields of the current arbitration winner
    always_comb begin
        sel_we = grant_id ? m1.we : m0.we;
        sel_a  = grant_id ? m1.a  : m0.a;
        sel_wd = grant_id ? m1.wd : m0.wd;
    end

    // Sequencer: latch winner, issue to GPIO for one cycle, then acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            gnt_q   <= 2'b00;
            ack_q   <= 2'b00;
            rd0_q   <= '0;
            rd1_q   <= '0;
            gpio_a  <= '0;
            gpio_we <= 1'b0;
            gpio_wd <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= ISSUE;
                        win_q   <= grant_id;
                        gpio_a  <= sel_a;
                        gpio_wd <= sel_wd;
                        gpio_we <= sel_we;
                        gnt_q   <= grant_id ? 2'b10 : 2'b01;
                    end
                end
                ISSUE: begin
                    // Same edge as the slave's register update: writes return old data
                    if (win_q) begin
                        rd1_q <= gpio_rd;
                    end else begin
                        rd0_q <= gpio_rd;
                    end
                    gpio_we <= 1'b0;
                    ack_q   <= gnt_q;
                    state_q <= RESP;
                end
                RESP: begin
                    gnt_q   <= 2'b00;
                    ack_q   <= 2'b00;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m0.gnt = gnt_q[0];
    assign m0.ack = ack_q[0];
    assign m0.rd  = rd0_q;
    assign m1.gnt = gnt_q[1];
    assign m1.ack = ack_q[1];
    assign m1.rd  = rd1_q;

endmodule
